// File: rtl/out_bcd_display.sv
// Result display stage: sequential double-dabble (one bit per clock) into DIGITS
// registered BCD codes and 7-segment patterns. Define OUT_BCD_SIGNED_EN for two's-complement input.
module out_bcd_display #(
    parameter int DATA_W         = 32,
    parameter int DIGITS         = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     result_ULA,
    input  logic                  controle,
    output logic                  busy,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   digits_bcd,
    output logic [7*DIGITS-1:0]   seg
);

    // Decimal digits needed for 2^DATA_W-1; widened so the low DIGITS nibbles always exist.
    localparam int NB_MIN = (DATA_W * 30103) / 100000 + 1;
    localparam int NB     = (NB_MIN > DIGITS) ? NB_MIN : DIGITS;
    localparam int CW     = $clog2(DATA_W + 1);
    localparam logic [6:0] SEG_DASH = SEG_ACTIVE_LOW ? 7'h3F : 7'h40;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t                r_state, w_next;
    logic [DATA_W-1:0]     r_sr, r_pend;
    logic [4*NB-1:0]       r_acc, w_acc_adj;
    logic [CW-1:0]         r_cnt;
    logic                  r_pend_vld, r_neg;
    logic [4*DIGITS-1:0]   r_digits, w_digits;
    logic [7*DIGITS-1:0]   r_seg, w_seg;
    logic                  r_ovf, w_ovf;
    logic                  w_start, w_cap_neg;
    logic [DATA_W-1:0]     w_cap, w_cap_mag;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            4'hE:    s = 7'h40;
            default: s = 7'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    assign w_start = (r_state == IDLE) && (r_pend_vld || controle);
    assign w_cap   = r_pend_vld ? r_pend : result_ULA;

`ifdef OUT_BCD_SIGNED_EN
    // Negation wraps for the most-negative value, which is exactly its unsigned magnitude.
    assign w_cap_neg = w_cap[DATA_W-1];
    assign w_cap_mag = w_cap_neg ? (-w_cap) : w_cap;
`else
    assign w_cap_neg = 1'b0;
    assign w_cap_mag = w_cap;
`endif

    always_comb begin
        w_acc_adj = r_acc;
        for (int i = 0; i < NB; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = CONVERT;
            CONVERT: if (r_cnt == CW'(1)) w_next = UPDATE;
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Minus sign takes the top digit, so overflow starts one nibble lower for negatives.
    always_comb begin
        w_digits = r_acc[4*DIGITS-1:0];
        w_ovf    = 1'b0;
        w_seg    = '0;
        if (r_neg) w_digits[4*DIGITS-1 -: 4] = 4'hE;
        for (int i = 0; i < NB; i++) begin
            if (((i >= DIGITS) || (r_neg && (i == DIGITS - 1))) && (r_acc[4*i +: 4] != 4'd0))
                w_ovf = 1'b1;
        end
        for (int i = 0; i < DIGITS; i++) w_seg[7*i +: 7] = f_seg(w_digits[4*i +: 4]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sr       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_neg      <= 1'b0;
            r_digits   <= {DIGITS{4'hE}};
            r_seg      <= {DIGITS{SEG_DASH}};
            r_ovf      <= 1'b0;
        end else begin
            if (r_state != IDLE && controle) begin
                r_pend     <= result_ULA;
                r_pend_vld <= 1'b1;
            end else if (w_start && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end
            case (r_state)
                IDLE: if (w_start) begin
                    r_sr  <= w_cap_mag;
                    r_neg <= w_cap_neg;
                    r_acc <= '0;
                    r_cnt <= CW'(DATA_W);
                end
                CONVERT: begin
                    {r_acc, r_sr} <= {w_acc_adj, r_sr} << 1;
                    r_cnt         <= r_cnt - CW'(1);
                end
                UPDATE: begin
                    r_digits <= w_digits;
                    r_seg    <= w_seg;
                    r_ovf    <= w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != IDLE);
    assign overflow   = r_ovf;
    assign digits_bcd = r_digits;
    assign seg        = r_seg;

endmodule

// File: tb/tb_out_bcd_display.sv
// Bench for out_bcd_display: decimal-arithmetic reference model checked every cycle,
// plus directed literal expectations and a randomized load/reset phase.
module tb_out_bcd_display;
    localparam int DW = 32;
    localparam int DG = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              controle = 1'b0;
    logic [DW-1:0]     result_ULA = '0;
    logic              busy, overflow;
    logic [4*DG-1:0]   digits_bcd;
    logic [7*DG-1:0]   seg;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    out_bcd_display #(.DATA_W(DW), .DIGITS(DG), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .result_ULA(result_ULA), .controle(controle),
        .busy(busy), .overflow(overflow), .digits_bcd(digits_bcd), .seg(seg)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_exp(input logic [3:0] d);
        logic [6:0] lit;
        case (d)
            4'd0: lit = 7'b0111111;  4'd1: lit = 7'b0000110;
            4'd2: lit = 7'b1011011;  4'd3: lit = 7'b1001111;
            4'd4: lit = 7'b1100110;  4'd5: lit = 7'b1101101;
            4'd6: lit = 7'b1111101;  4'd7: lit = 7'b0000111;
            4'd8: lit = 7'b1111111;  4'd9: lit = 7'b1101111;
            4'hE: lit = 7'b1000000;  default: lit = 7'b0000000;
        endcase
        return ~lit;
    endfunction

    // Decimal rendering of a loaded value by plain division.
    function automatic void show(input logic [DW-1:0] v, output logic [4*DG-1:0] dg, output bit ov);
        longint unsigned mag, p;
        bit neg;
        int nd;
        neg = 1'b0;
`ifdef OUT_BCD_SIGNED_EN
        neg = v[DW-1];
`endif
        mag = neg ? ((64'd1 << DW) - 64'(v)) : 64'(v);
        nd  = neg ? DG - 1 : DG;
        p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        ov = (mag >= p);
        p = 1;
        for (int i = 0; i < DG; i++) begin
            dg[4*i +: 4] = (neg && i == DG - 1) ? 4'hE : 4'((mag / p) % 10);
            p = p * 10;
        end
    endfunction

    // Model: a load occupies DW+1 busy cycles; loads while busy keep only the latest.
    int              m_left = 0;
    bit              m_pend_v = 1'b0;
    logic [DW-1:0]   m_pend = '0, m_val = '0;
    logic [4*DG-1:0] m_digits = {DG{4'hE}};
    bit              m_ovf = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        int left; bit pv; logic [DW-1:0] val, pend; logic [4*DG-1:0] dg; bit ov;
        left = m_left; pv = m_pend_v; val = m_val; pend = m_pend; dg = m_digits; ov = m_ovf;
        if (!reset_n) begin
            left = 0; pv = 1'b0; dg = {DG{4'hE}}; ov = 1'b0;
        end else if (left == 0) begin
            if (pv || controle) begin
                val  = pv ? pend : result_ULA;
                pv   = 1'b0;
                left = DW + 1;
            end
        end else begin
            if (controle) begin pend = result_ULA; pv = 1'b1; end
            left--;
            if (left == 0) show(val, dg, ov);
        end
        m_left <= left; m_pend_v <= pv; m_val <= val; m_pend <= pend;
        m_digits <= dg; m_ovf <= ov;
    end

    always @(negedge clock) begin
        logic [7*DG-1:0] es;
        for (int i = 0; i < DG; i++) es[7*i +: 7] = seg_exp(m_digits[4*i +: 4]);
        chk("model_digits", digits_bcd, m_digits);
        chk("model_seg", seg, es);
        chk("model_busy", busy, m_left != 0);
        chk("model_ovf", overflow, m_ovf);
    end

    int  conv_cnt = 0;
    bit  seen11 = 1'b0;
    bit  prev_busy = 1'b0;
    always @(negedge clock) begin
        if (busy && !prev_busy) conv_cnt++;
        if (digits_bcd == 16'h0011) seen11 = 1'b1;
        prev_busy = busy;
    end

    task automatic load(input logic [DW-1:0] v);
        @(negedge clock);
        result_ULA = v;
        controle = 1'b1;
        @(posedge clock);
        #1 controle = 1'b0;
    endtask

    task automatic wait_done(output int n, output int bc);
        n = 0;
        bc = busy ? 1 : 0;
        while (busy && n < 100) begin
            @(posedge clock);
            #1;
            n++;
            if (busy) bc++;
        end
    endtask

    initial begin
        int n, bc, conv0, w;
        repeat (3) @(negedge clock);
        #1;
        chk("reset_digits", digits_bcd, 16'hEEEE);
        chk("reset_seg", seg, {4{7'b0111111}});
        chk("reset_busy", busy, 1'b0);
        chk("reset_ovf", overflow, 1'b0);
        #1 reset_n = 1'b1;

        load(1234);
        wait_done(n, bc);
        chk("latency_1234", n, 33);
        chk("busy_cycles_1234", bc, 33);
        chk("digits_1234", digits_bcd, 16'h1234);
        chk("seg_1234", seg, {7'h79, 7'h24, 7'h30, 7'h19});
        chk("ovf_1234", overflow, 1'b0);

        load(98765);
        wait_done(n, bc);
        chk("digits_98765", digits_bcd, 16'h8765);
        chk("ovf_98765", overflow, 1'b1);
        repeat (5) @(negedge clock);
        chk("hold_8765", digits_bcd, 16'h8765);
        load(7);
        wait_done(n, bc);
        chk("digits_7", digits_bcd, 16'h0007);
        chk("ovf_7", overflow, 1'b0);

        conv0 = conv_cnt;
        load(5);
        repeat (3) @(posedge clock);
        load(11);
        repeat (2) @(posedge clock);
        load(22);
        wait_done(n, bc);
        chk("digits_5", digits_bcd, 16'h0005);
        w = 0;
        while (!busy && w < 10) begin @(posedge clock); #1; w++; end
        chk("pending_start", busy, 1'b1);
        wait_done(n, bc);
        chk("digits_22", digits_bcd, 16'h0022);
        chk("never_11", seen11, 1'b0);
        chk("conversions", conv_cnt - conv0, 2);

        load(4321);
        repeat (10) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("midreset_digits", digits_bcd, 16'hEEEE);
        chk("midreset_seg", seg, {4{7'b0111111}});
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_ovf", overflow, 1'b0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        load(9);
        wait_done(n, bc);
        chk("digits_9", digits_bcd, 16'h0009);

`ifdef OUT_BCD_SIGNED_EN
        load(32'hFFFF_FFD6);
        wait_done(n, bc);
        chk("digits_m42", digits_bcd, 16'hE042);
        chk("ovf_m42", overflow, 1'b0);
        load(32'h8000_0000);
        wait_done(n, bc);
        chk("digits_minneg", digits_bcd, 16'hE648);
        chk("ovf_minneg", overflow, 1'b1);
`endif

        repeat (3000) begin
            @(negedge clock);
            controle = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: result_ULA = DW'($urandom_range(0, 9999));
                1: result_ULA = $urandom;
                2: result_ULA = DW'($urandom_range(9995, 10005));
                default: result_ULA = DW'($urandom_range(0, 20));
            endcase
            if ($urandom_range(0, 599) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clock);
                #2 reset_n = 1'b1;
            end
        end
        @(negedge clock);
        controle = 1'b0;
        repeat (80) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
